// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: mode-0 SPI slave that decodes 16-bit write frames into five PWM config registers; ncs rise to update is SYNC_STAGES+2 clk.
// No backpressure: the host must respect SPI timing limits. Optional readback on cipo is enabled by the SPI_READBACK_EN macro.
module spi_reg_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q, vld_q;
  logic                   sclk_dly_q, ncs_dly_q, armed_q;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_rise, ncs_fall;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [15:0] shreg_q;
  logic [7:0]  regs_q [5];
  logic [6:0]  addr;
  logic        addr_ok;

  // vld_q tracks when the sync chain holds only post-reset samples, so a
  // low ncs at reset release cannot masquerade as a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      vld_q       <= '0;
      sclk_dly_q  <= 1'b0;
      ncs_dly_q   <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      sclk_dly_q  <= sclk_s;
      ncs_dly_q   <= ncs_s;
      if (vld_q[SYNC_STAGES-1] && ncs_s) armed_q <= 1'b1;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign ncs_rise  = ncs_s & ~ncs_dly_q;
  assign ncs_fall  = ~ncs_s & ncs_dly_q;

  assign addr    = shreg_q[14:8];
  assign addr_ok = (addr <= MAX_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < 5; i++) regs_q[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ncs_fall && armed_q) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            shreg_q <= '0;
          end
        end
        SHIFT: begin
          // ncs rise wins over a coincident sclk rise
          if (ncs_rise) begin
            if (cnt_q == 5'd16) begin
              state_q <= COMMIT;
            end else begin
              state_q   <= IDLE;
              frame_err <= 1'b1;
            end
          end else if (sclk_rise) begin
            if (cnt_q < 5'd16) begin
              shreg_q <= {shreg_q[14:0], copi_s};
              cnt_q   <= cnt_q + 5'd1;
            end else begin
              cnt_q <= 5'd17;
            end
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          if (shreg_q[15] && addr_ok) begin
            wr_strobe <= 1'b1;
            if (addr < 7'd5) regs_q[addr[2:0]] <= shreg_q[7:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [6:0] rd_addr;
  logic [7:0] rd_dat;
  logic [7:0] out_sr_q;
  logic       rd_q;
  logic       cipo_q;

  assign sclk_fall = ~sclk_s & sclk_dly_q;
  // The 8th bit is still in the synchroniser when the rise is seen.
  assign rd_addr   = {shreg_q[5:0], copi_s};

  always_comb begin
    rd_dat = 8'h00;
    if (rd_addr <= MAX_A && rd_addr < 7'd5) rd_dat = regs_q[rd_addr[2:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sr_q <= '0;
      rd_q     <= 1'b0;
      cipo_q   <= 1'b0;
    end else if (state_q != SHIFT || ncs_rise) begin
      rd_q   <= 1'b0;
      cipo_q <= 1'b0;
    end else if (sclk_rise && cnt_q == 5'd7) begin
      rd_q     <= ~shreg_q[6];
      out_sr_q <= rd_dat;
    end else if (sclk_fall) begin
      if (rd_q && cnt_q >= 5'd8 && cnt_q <= 5'd15) begin
        cipo_q   <= out_sr_q[7];
        out_sr_q <= {out_sr_q[6:0], 1'b0};
      end else begin
        cipo_q <= 1'b0;
      end
    end
  end

  assign cipo = cipo_q;
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl (SYNC_STAGES=2): writes, latency, bad frames, mid-frame reset, optional readback.
module tb_spi_reg_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic       cipo;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_strobe, frame_err;

  int n_chk = 0;
  int n_fail = 0;
  int strobe_cnt = 0;

  spi_reg_ctrl #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

  function automatic logic [39:0] regs();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  // Each bit: 6 clk low with copi set, then 6 clk high; cipo sampled just before the rise.
  task automatic send_bits(input logic [15:0] d, input int from, input int n, output logic [15:0] rd);
    rd = '0;
    for (int i = from; i < from + n; i++) begin
      copi = (i < 16) ? d[15-i] : 1'b0;
      repeat (6) @(negedge clk);
      if (i < 16) rd[15-i] = cipo;
      sclk = 1'b1;
      repeat (6) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [15:0] d, input int n);
    logic [15:0] rd;
    @(negedge clk);
    ncs = 1'b0;
    repeat (6) @(negedge clk);
    send_bits(d, 0, n, rd);
    repeat (6) @(negedge clk);
    ncs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (regs() !== 40'h0) begin n_fail++; $display("FAIL reset_regs_in_reset got %h want 0", regs()); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_chk++; if (regs() !== 40'h0) begin n_fail++; $display("FAIL reset_regs got %h want 0", regs()); end
    n_chk++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got %b want 0", wr_strobe); end
    n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    n_chk++; if (cipo !== 1'b0) begin n_fail++; $display("FAIL reset_cipo got %b want 0", cipo); end
  endtask

  task automatic test_write_latency();
    logic [15:0] rd;
    int s0;
    s0 = strobe_cnt;
    @(negedge clk);
    ncs = 1'b0;
    repeat (6) @(negedge clk);
    send_bits(16'h8055, 0, 16, rd);
    repeat (6) @(negedge clk);
    ncs = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      n_chk++;
      if (wr_strobe !== (c == 4)) begin
        n_fail++; $display("FAIL write_strobe_cycle%0d got %b want %b", c, wr_strobe, (c == 4));
      end
      if (c == 3) begin
        n_chk++; if (en_reg_out_7_0 !== 8'h00) begin n_fail++; $display("FAIL write_early_value got %h want 00", en_reg_out_7_0); end
      end
      if (c == 4) begin
        n_chk++; if (en_reg_out_7_0 !== 8'h55) begin n_fail++; $display("FAIL write_value got %h want 55", en_reg_out_7_0); end
      end
    end
    repeat (10) @(negedge clk);
    n_chk++; if (regs() !== 40'h00_00_00_00_55) begin n_fail++; $display("FAIL write_regs got %h want 0000000055", regs()); end
    n_chk++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL write_strobe_count got %0d want 1", strobe_cnt - s0); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd;
    int s0;
    s0 = strobe_cnt;
    @(negedge clk);
    ncs = 1'b0;
    repeat (6) @(negedge clk);
    send_bits(16'h8480, 0, 16, rd);
    repeat (6) @(negedge clk);
    ncs = 1'b1;
    repeat (5) @(negedge clk);
    ncs = 1'b0;
    repeat (6) @(negedge clk);
    send_bits(16'h82FF, 0, 16, rd);
    repeat (6) @(negedge clk);
    ncs = 1'b1;
    repeat (10) @(negedge clk);
    n_chk++; if (pwm_duty_cycle !== 8'h80) begin n_fail++; $display("FAIL b2b_duty got %h want 80", pwm_duty_cycle); end
    n_chk++; if (en_reg_pwm_7_0 !== 8'hFF) begin n_fail++; $display("FAIL b2b_pwm_7_0 got %h want ff", en_reg_pwm_7_0); end
    n_chk++; if (regs() !== 40'h80_00_FF_00_55) begin n_fail++; $display("FAIL b2b_regs got %h want 8000ff0055", regs()); end
    n_chk++; if (strobe_cnt - s0 !== 2) begin n_fail++; $display("FAIL b2b_strobe_count got %0d want 2", strobe_cnt - s0); end
  endtask

  task automatic test_bad_addr_and_read();
    int s0;
    s0 = strobe_cnt;
    frame(16'h85AA, 16);
    frame(16'h0412, 16);
    n_chk++; if (regs() !== 40'h80_00_FF_00_55) begin n_fail++; $display("FAIL noop_regs got %h want 8000ff0055", regs()); end
    n_chk++; if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL noop_strobe_count got %0d want 0", strobe_cnt - s0); end
    n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL noop_frame_err got %b want 0", frame_err); end
  endtask

  task automatic test_malformed();
    int s0;
    s0 = strobe_cnt;
    frame(16'h8177, 12);
    n_chk++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL short_frame_err got %b want 1", frame_err); end
    frame(16'h8144, 17);
    n_chk++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL long_frame_err got %b want 1", frame_err); end
    n_chk++; if (regs() !== 40'h80_00_FF_00_55) begin n_fail++; $display("FAIL malformed_regs got %h want 8000ff0055", regs()); end
    n_chk++; if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL malformed_strobe_count got %0d want 0", strobe_cnt - s0); end
    frame(16'h8133, 16);
    n_chk++; if (en_reg_out_15_8 !== 8'h33) begin n_fail++; $display("FAIL recover_out_15_8 got %h want 33", en_reg_out_15_8); end
    n_chk++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL sticky_frame_err got %b want 1", frame_err); end
    n_chk++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL recover_strobe_count got %0d want 1", strobe_cnt - s0); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] rd;
    int s0;
    @(negedge clk);
    ncs = 1'b0;
    repeat (6) @(negedge clk);
    send_bits(16'h83C3, 0, 8, rd);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    s0 = strobe_cnt;
    rst_n = 1'b1;
    send_bits(16'h83C3, 8, 8, rd);
    repeat (6) @(negedge clk);
    ncs = 1'b1;
    repeat (10) @(negedge clk);
    n_chk++; if (en_reg_pwm_15_8 !== 8'h00) begin n_fail++; $display("FAIL midrst_pwm_15_8 got %h want 00", en_reg_pwm_15_8); end
    n_chk++; if (regs() !== 40'h0) begin n_fail++; $display("FAIL midrst_regs got %h want 0", regs()); end
    n_chk++; if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL midrst_strobe_count got %0d want 0", strobe_cnt - s0); end
    n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_err got %b want 0", frame_err); end
    frame(16'h83C3, 16);
    n_chk++; if (en_reg_pwm_15_8 !== 8'hC3) begin n_fail++; $display("FAIL postrst_pwm_15_8 got %h want c3", en_reg_pwm_15_8); end
    n_chk++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL postrst_strobe_count got %0d want 1", strobe_cnt - s0); end
  endtask

`ifdef SPI_READBACK_EN
  task automatic test_readback();
    logic [15:0] rd;
    frame(16'h84A5, 16);
    @(negedge clk);
    ncs = 1'b0;
    repeat (6) @(negedge clk);
    send_bits(16'h0400, 0, 16, rd);
    repeat (6) @(negedge clk);
    ncs = 1'b1;
    repeat (10) @(negedge clk);
    n_chk++; if (rd[7:0] !== 8'hA5) begin n_fail++; $display("FAIL readback_data got %h want a5", rd[7:0]); end
    n_chk++; if (rd[15:8] !== 8'h00) begin n_fail++; $display("FAIL readback_header_bits got %h want 00", rd[15:8]); end
    n_chk++; if (cipo !== 1'b0) begin n_fail++; $display("FAIL readback_idle_cipo got %b want 0", cipo); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_latency();
    test_back_to_back();
    test_bad_addr_and_read();
    test_malformed();
    test_reset_midframe();
`ifdef SPI_READBACK_EN
    test_readback();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

SPI-slave configuration controller for the PWM peripheral in the top-level wrapper. It receives 16-bit write frames from an external host over a mode-0 SPI bus and decodes them into the five 8-bit configuration registers. Those registers drive `pwm_peripheral` directly: output enables, PWM enables and duty cycle. All SPI pins are asynchronous to `clk` and are synchronised internally, so the block is the only path by which the host reconfigures the PWM datapath.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop stages on each of `sclk`, `copi` and `ncs`; legal range is 2 or more.
- `MAX_ADDR`, 4: highest valid register address; writes above it are dropped.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `sclk`  in  1  SPI clock from the host, asynchronous.
- `copi`  in  1  SPI data from the host, MSB first.
- `ncs`  in  1  SPI chip select, active-low.
- `cipo`  out  1  SPI read data; driven only when `SPI_READBACK_EN` is defined, otherwise constant 0.
- `en_reg_out_7_0`  out  8  address 0x00.
- `en_reg_out_15_8`  out  8  address 0x01.
- `en_reg_pwm_7_0`  out  8  address 0x02.
- `en_reg_pwm_15_8`  out  8  address 0x03.
- `pwm_duty_cycle`  out  8  address 0x04.
- `wr_strobe`  out  1  one-cycle pulse when a register is written.
- `frame_err`  out  1  sticky flag for a malformed frame; cleared only by reset.

## Operation
- **Frame format:** bit15 is R/W (1 = write), bits[14:8] are the 7-bit address, bits[7:0] are data. Bits are shifted MSB first.
- **Edge detection:** performed on the synchronised signals by comparing the current value with a one-cycle-delayed copy.
  - `sclk` rise = sync 1, delayed 0.
  - `sclk` fall = sync 0, delayed 1.
  - `ncs` rise/fall are detected the same way.
- **State machine:** IDLE, SHIFT, COMMIT.
  - IDLE → SHIFT on an `ncs` falling edge; clears the 5-bit bit counter and the 16-bit shift register.
  - In SHIFT, each `sclk` rising edge shifts `copi` in and increments the counter while the count is below 16.
  - A 17th `sclk` rise sets the counter to 17 (overrun); further edges are ignored.
  - SHIFT → COMMIT on an `ncs` rising edge when the count is exactly 16.
  - SHIFT → IDLE on an `ncs` rising edge when the count is not 16; the frame is discarded and `frame_err` is set.
  - COMMIT → IDLE unconditionally after one cycle.
- **COMMIT actions:**
  - R/W = 1 and address ≤ `MAX_ADDR`: write data to the addressed register and assert `wr_strobe` for that cycle.
  - Address > `MAX_ADDR`: no write, no strobe, no error.
  - R/W = 0: no register changes, no strobe.
- **Simultaneous events:** an `ncs` rise in the same cycle as an `sclk` rise takes priority; that `sclk` edge is not counted.
- **Reset:**
  - All five registers, `wr_strobe`, `frame_err`, `cipo`, the counter and the shift register reset to 0; state resets to IDLE.
  - Synchroniser flops reset to `sclk`=0, `copi`=0, `ncs`=1.
  - A reset mid-frame discards the frame.
  - If `ncs` is already low when reset is released, no frame starts until `ncs` goes high and then falls again.
- Registers hold their values indefinitely between writes.

## Timing
- `ncs` rising edge at the pin to register update and `wr_strobe`: exactly `SYNC_STAGES`+2 `clk` rising edges.
  - The first of those edges is the one that samples `ncs` high.
  - `wr_strobe` is high for exactly one cycle, coincident with the first cycle in which the new register value is visible.
- Minimum `sclk` high time and minimum `sclk` low time: `SYNC_STAGES`+2 `clk` periods each.
- `copi` must be stable from `SYNC_STAGES`+1 `clk` periods before an `sclk` rise until 1 period after it.
- `ncs` high time between frames: at least `SYNC_STAGES`+3 `clk` periods.
- Back-to-back frames that meet these limits are never dropped.

## Configuration
- Macro: `SPI_READBACK_EN`.
- **Defined:**
  - When the 8th `sclk` rise of a frame has R/W = 0 and address ≤ `MAX_ADDR`, load the addressed register into an 8-bit output shift register.
  - On each subsequent synchronised `sclk` falling edge, drive its next bit on `cipo`, MSB first.
  - `cipo` returns to 0 when `ncs` is high or after the 16th bit.
  - An address > `MAX_ADDR` reads as 0x00.
- **Undefined:** the output shift logic is absent, `cipo` is constant 0, and reads are no-ops.

## Test plan
- Reset, then write frame 0x8055 → `en_reg_out_7_0`=0x55; one `wr_strobe` pulse `SYNC_STAGES`+2 cycles after the `ncs` rise; other registers stay 0x00.
- Write 0x8480 then 0x82FF back-to-back at minimum `ncs` gap → `pwm_duty_cycle`=0x80, `en_reg_pwm_7_0`=0xFF, two strobes.
- Write 0x85AA (address 5) and a read frame 0x0412 → all registers unchanged, no strobe, `frame_err`=0.
- Frame with 12 clocks, then a separate frame with 17 clocks → both discarded, `frame_err`=1 after the first and held; a following valid 0x8133 sets `en_reg_out_15_8`=0x33.
- Assert `rst_n` low after 8 bits of 0x83C3, release while `ncs` is low, continue clocking → `en_reg_pwm_15_8`=0x00, no strobe; next full frame is accepted.
- With `SPI_READBACK_EN`: write 0x84A5, then read frame 0x0400 → `cipo` shifts out 1010_0101 on bits 8–15.
